// File: rtl/tx_arbiter_if.sv
// Handshake bundle between the two byte requesters, the UART transmitter and tx_arbiter.
// master: requesters + UART side (drives requests and tx_ack).
// slave: the arbiter.
interface tx_arbiter_if;
  logic       en;
  logic [7:0] p0_data;
  logic       p0_valid;
  logic       p0_ack;
  logic [7:0] p1_data;
  logic       p1_valid;
  logic       p1_last;
  logic       p1_ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       tx_ack;
  logic       lock;
  logic       lock_timeout;

  modport master (
    output en, p0_data, p0_valid, p1_data, p1_valid, p1_last, tx_ack,
    input  p0_ack, p1_ack, out_data, out_valid, lock, lock_timeout
  );

  modport slave (
    input  en, p0_data, p0_valid, p1_data, p1_valid, p1_last, tx_ack,
    output p0_ack, p1_ack, out_data, out_valid, lock, lock_timeout
  );
endinterface

// File: rtl/tx_arbiter.sv
// Two-port byte arbiter feeding a UART transmitter. Port 0 carries meter traffic, port 1
// carries multi-byte status messages that lock the output until their last byte. Bytes are
// separated by GAP_CYCLES idle cycles, and a stalled port-1 message releases its lock after
// LOCK_TIMEOUT idle cycles.
module tx_arbiter #(
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned LOCK_TIMEOUT = 255
) (
  input logic         clk,
  input logic         rst,
  tx_arbiter_if.slave bus
);

  localparam logic [3:0] GapLast  = 4'(GAP_CYCLES - 1);
  localparam logic [7:0] LockLast = 8'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e     state_q, state_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic       lock_q, lock_d;
  logic       last_p1_q, last_p1_d;  // 1: port 1 was served last
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       lock_timeout_q, lock_timeout_d;
  logic       grant_p0, grant_p1;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      gap_cnt_q      <= '0;
      lock_cnt_q     <= '0;
      lock_q         <= 1'b0;
      last_p1_q      <= 1'b1;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      lock_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      gap_cnt_q      <= gap_cnt_d;
      lock_cnt_q     <= lock_cnt_d;
      lock_q         <= lock_d;
      last_p1_q      <= last_p1_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end

  // Grant selection, next-state and lock-timer logic.
  always_comb begin
    state_d        = state_q;
    gap_cnt_d      = gap_cnt_q;
    lock_cnt_d     = lock_cnt_q;
    lock_d         = lock_q;
    last_p1_d      = last_p1_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    lock_timeout_d = 1'b0;
    grant_p0       = 1'b0;
    grant_p1       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          if (lock_q) begin
            grant_p1 = bus.p1_valid;
          end else if (bus.p0_valid && bus.p1_valid) begin
            grant_p0 = last_p1_q;
            grant_p1 = ~last_p1_q;
          end else begin
            grant_p0 = bus.p0_valid;
            grant_p1 = bus.p1_valid;
          end
        end

        if (grant_p0) begin
          out_data_d  = bus.p0_data;
          out_valid_d = 1'b1;
          last_p1_d   = 1'b0;
          state_d     = StSend;
        end else if (grant_p1) begin
          out_data_d  = bus.p1_data;
          out_valid_d = 1'b1;
          last_p1_d   = 1'b1;
          lock_d      = ~bus.p1_last;
          lock_cnt_d  = '0;
          state_d     = StSend;
        end else if (lock_q) begin
          // Held lock with no port-1 byte this cycle; counts even while en is low.
          if (lock_cnt_q == LockLast) begin
            lock_d         = 1'b0;
            lock_timeout_d = 1'b1;
            lock_cnt_d     = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 8'd1;
          end
        end
      end

      StSend: begin
        if (bus.tx_ack) begin
          out_valid_d = 1'b0;
          gap_cnt_d   = '0;
          state_d     = StGap;
        end
      end

      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end

      default: state_d = StIdle;
    endcase

    if (!lock_d) begin
      lock_cnt_d = '0;
    end
  end

  // Acks are same-cycle pulses; reset forces them low even though they are combinational.
  assign bus.p0_ack       = grant_p0 & ~rst;
  assign bus.p1_ack       = grant_p1 & ~rst;
  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.lock         = lock_q;
  assign bus.lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level model (busy flag, ready-time arithmetic, lock/idle counting).
module tb_tx_arbiter;
  localparam int unsigned GapCycles   = 2;
  localparam int unsigned LockTimeout = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tx_arbiter_if bus ();

  tx_arbiter #(
    .GAP_CYCLES  (GapCycles),
    .LOCK_TIMEOUT(LockTimeout)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Stimulus intent for the next cycle.
  logic       en_r  = 1'b0;
  logic       p0v_r = 1'b0;
  logic       p1v_r = 1'b0;
  logic       p1l_r = 1'b0;
  logic [7:0] p0d_r = 8'h00;
  logic [7:0] p1d_r = 8'h00;
  bit         auto_ack = 1'b1;
  bit         spur_ack = 1'b0;
  int         tx_delay = 1;

  // Reference model.
  int         cyc      = 0;
  int         ready_at = 0;   // first cycle the arbiter may grant again
  int         age      = 0;   // cycles the current byte has been presented
  int         m_cnt    = 0;   // idle cycles spent under lock
  bit         m_busy   = 1'b0;
  bit         m_lock   = 1'b0;
  bit         m_last_p1 = 1'b1;
  bit         m_to     = 1'b0;
  logic [7:0] m_data   = 8'h00;
  bit         g0, g1, txa;

  // Observation logs.
  bit         prev_ov = 1'b0;
  logic [7:0] sent_q[$];
  int         grant_q[$];
  int         to_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ready_at  = 0;
    age       = 0;
    m_cnt     = 0;
    m_busy    = 1'b0;
    m_lock    = 1'b0;
    m_last_p1 = 1'b1;
    m_to      = 1'b0;
    m_data    = 8'h00;
    prev_ov   = 1'b0;
  endtask

  task automatic drive_zero();
    bus.en = 1'b0; bus.p0_valid = 1'b0; bus.p0_data = 8'h00;
    bus.p1_valid = 1'b0; bus.p1_data = 8'h00; bus.p1_last = 1'b0; bus.tx_ack = 1'b0;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    @(negedge clk);
    drive_zero();
    rst = 1'b1;
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
    check_eq("rst_lock", 32'(bus.lock), 32'd0);
    check_eq("rst_lock_timeout", 32'(bus.lock_timeout), 32'd0);
    check_eq("rst_p0_ack", 32'(bus.p0_ack), 32'd0);
    check_eq("rst_p1_ack", 32'(bus.p1_ack), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic step();
    bit idle;
    @(negedge clk);
    idle = !m_busy && (cyc >= ready_at);
    if (m_busy) txa = auto_ack && (age >= tx_delay);
    else        txa = spur_ack && ($urandom_range(0, 3) == 0);
    bus.en = en_r; bus.p0_valid = p0v_r; bus.p0_data = p0d_r;
    bus.p1_valid = p1v_r; bus.p1_data = p1d_r; bus.p1_last = p1l_r; bus.tx_ack = txa;
    g0 = 1'b0;
    g1 = 1'b0;
    if (idle && en_r) begin
      if (m_lock)                g1 = p1v_r;
      else if (p0v_r && p1v_r) begin g0 = m_last_p1; g1 = !m_last_p1; end
      else begin g0 = p0v_r; g1 = p1v_r; end
    end
    #1;
    check_eq("p0_ack", 32'(bus.p0_ack), 32'(g0));
    check_eq("p1_ack", 32'(bus.p1_ack), 32'(g1));
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_busy));
    check_eq("out_data", 32'(bus.out_data), 32'(m_data));
    check_eq("lock", 32'(bus.lock), 32'(m_lock));
    check_eq("lock_timeout", 32'(bus.lock_timeout), 32'(m_to));
    if (bus.p0_ack) grant_q.push_back(0);
    if (bus.p1_ack) grant_q.push_back(1);
    if (bus.out_valid && !prev_ov) sent_q.push_back(bus.out_data);
    prev_ov = bus.out_valid;
    if (bus.lock_timeout) to_seen++;
    @(posedge clk);
    m_to = 1'b0;
    if (g0 || g1) begin
      m_busy    = 1'b1;
      age       = 0;
      m_data    = g0 ? p0d_r : p1d_r;
      m_last_p1 = g1;
      if (g1) begin
        m_lock = !p1l_r;
        m_cnt  = 0;
      end
    end else if (idle && m_lock) begin
      m_cnt++;
      if (m_cnt == int'(LockTimeout)) begin
        m_lock = 1'b0;
        m_to   = 1'b1;
        m_cnt  = 0;
      end
    end else if (m_busy) begin
      if (txa) begin
        m_busy   = 1'b0;
        ready_at = cyc + 1 + int'(GapCycles);
      end else begin
        age++;
      end
    end
    cyc++;
  endtask

  initial begin
    int k;
    drive_zero();
    do_reset();

    // Single p0 byte 0x41, tx_ack three cycles after out_valid rises.
    en_r = 1'b1; p0v_r = 1'b1; p0d_r = 8'h41; tx_delay = 3;
    sent_q.delete();
    for (int i = 0; i < 14; i++) begin
      step();
      if (g0) p0v_r = 1'b0;
    end
    check_eq("single_count", 32'(sent_q.size()), 32'd1);
    check_eq("single_data", 32'(sent_q[0]), 32'h41);

    // p1 three-byte message with p0 waiting; p0 was served last so p1 goes first.
    sent_q.delete();
    k = 0; p0v_r = 1'b1; p0d_r = 8'h30; tx_delay = 1;
    for (int i = 0; i < 30; i++) begin
      p1v_r = (k < 3);
      p1d_r = 8'h10 + 8'(k);
      p1l_r = (k == 2);
      step();
      if (g1) k++;
    end
    p0v_r = 1'b0; p1v_r = 1'b0; p1l_r = 1'b0;
    check_eq("msg_count", 32'(sent_q.size() >= 4), 32'd1);
    check_eq("msg_b0", 32'(sent_q[0]), 32'h10);
    check_eq("msg_b1", 32'(sent_q[1]), 32'h11);
    check_eq("msg_b2", 32'(sent_q[2]), 32'h12);
    check_eq("msg_b3", 32'(sent_q[3]), 32'h30);

    // Round-robin from reset: p0 wins the first tie.
    do_reset();
    grant_q.delete();
    en_r = 1'b1; p0v_r = 1'b1; p1v_r = 1'b1; p1l_r = 1'b1;
    p0d_r = 8'hA0; p1d_r = 8'hB0; tx_delay = 0;
    for (int i = 0; i < 30; i++) step();
    check_eq("rr_count", 32'(grant_q.size() >= 4), 32'd1);
    check_eq("rr_g0", 32'(grant_q[0]), 32'd0);
    check_eq("rr_g1", 32'(grant_q[1]), 32'd1);
    check_eq("rr_g2", 32'(grant_q[2]), 32'd0);
    check_eq("rr_g3", 32'(grant_q[3]), 32'd1);

    // Lock timeout: p1 starts a message and stalls, p0 byte pending.
    do_reset();
    sent_q.delete(); to_seen = 0;
    en_r = 1'b1; p0v_r = 1'b0; p1v_r = 1'b1; p1d_r = 8'h20; p1l_r = 1'b0; tx_delay = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (g1) begin p1v_r = 1'b0; p0v_r = 1'b1; p0d_r = 8'h5A; end
      if (g0) p0v_r = 1'b0;
    end
    check_eq("to_pulses", 32'(to_seen), 32'd1);
    check_eq("to_count", 32'(sent_q.size()), 32'd2);
    check_eq("to_b1", 32'(sent_q[1]), 32'h5A);

    // en low blocks grants for 20 cycles; raising it grants at once.
    do_reset();
    grant_q.delete();
    en_r = 1'b0; p0v_r = 1'b1; p0d_r = 8'h37;
    for (int i = 0; i < 20; i++) step();
    check_eq("en_blocked", 32'(grant_q.size()), 32'd0);
    en_r = 1'b1;
    step();
    check_eq("en_grant", 32'(grant_q.size()), 32'd1);
    p0v_r = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Reset while 0x55 is being presented: byte is dropped for good.
    do_reset();
    sent_q.delete();
    auto_ack = 1'b0; en_r = 1'b1; p0v_r = 1'b1; p0d_r = 8'h55;
    step();
    p0v_r = 1'b0;
    step();
    step();
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check_eq("rst_drop", 32'(sent_q.size()), 32'd1);

    // Randomized traffic in phases with different port densities.
    spur_ack = 1'b1;
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 399) == 0) do_reset();
        en_r  = ($urandom_range(0, 9) != 0);
        p0d_r = 8'($urandom);
        p1d_r = 8'($urandom);
        case (ph)
          0: begin p0v_r = $urandom_range(0, 1) == 1; p1v_r = $urandom_range(0, 1) == 1; end
          1: begin p0v_r = $urandom_range(0, 3) != 0; p1v_r = $urandom_range(0, 6) == 0; end
          2: begin p0v_r = $urandom_range(0, 5) == 0; p1v_r = $urandom_range(0, 3) != 0; end
          default: begin p0v_r = $urandom_range(0, 4) != 0; p1v_r = $urandom_range(0, 4) != 0; end
        endcase
        p1l_r = $urandom_range(0, 3) == 0;
        step();
        if (g0 || g1) tx_delay = $urandom_range(0, 4);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errs);
    $finish;
  end
endmodule
